// File: rtl/uart_frame_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_frame_pkg : shared types and sizing helpers for uart_frame_link      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_frame_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_ARM  = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } tx_state_t;

   // Width needed to hold values 0..max_val, never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_link_if.sv
// +--------------------------------------------------------------------------+
// | uart_frame_link_if : byte-level handshake between link and UART core      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface uart_frame_link_if;
   import uart_frame_pkg::*;

   logic [BYTE_W-1:0] rx_byte;
   logic              rx_rdy;
   logic              rx_rdy_clr;
   logic [BYTE_W-1:0] tx_byte;
   logic              tx_wr;
   logic              uart_busy;

   modport master (
      input  rx_byte, rx_rdy, uart_busy,
      output rx_rdy_clr, tx_byte, tx_wr
   );

   modport slave (
      output rx_byte, rx_rdy, uart_busy,
      input  rx_rdy_clr, tx_byte, tx_wr
   );

endinterface

`default_nettype wire

// File: rtl/uart_frame_tx_seq.sv
// +--------------------------------------------------------------------------+
// | uart_frame_tx_seq : MSB-first word serialiser with UART busy handshake.   |
// | Optional trailing XOR byte when UART_FRAME_CHECKSUM_EN is defined.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_frame_tx_seq
   import uart_frame_pkg::*;
#(
   parameter int TX_BYTES = 4
)(
   input  wire                         clock,
   input  wire                         reset,
   input  wire  [BYTE_W*TX_BYTES-1:0]  tx_word,
   input  wire                         tx_start,
   input  wire                         uart_busy,
   output logic                        tx_ready,
   output logic [BYTE_W-1:0]           tx_byte,
   output logic                        tx_wr,
   output logic                        tx_done
);

`ifdef UART_FRAME_CHECKSUM_EN
   localparam int CHK_BYTES = 1;
`else
   localparam int CHK_BYTES = 0;
`endif
   localparam int TOTAL  = TX_BYTES + CHK_BYTES;
   localparam int IDX_W  = cnt_width(TOTAL);
   localparam int WORD_W = BYTE_W * TX_BYTES;

   tx_state_t         state;
   logic [WORD_W-1:0] shadow;
   logic [IDX_W-1:0]  byte_idx;
   logic              start_q;
   logic [BYTE_W-1:0] next_byte;
`ifdef UART_FRAME_CHECKSUM_EN
   logic [BYTE_W-1:0] chk;
`endif

   always_comb begin
      next_byte = shadow[WORD_W-1 -: BYTE_W];
`ifdef UART_FRAME_CHECKSUM_EN
      if (byte_idx == IDX_W'(1))
         next_byte = chk;
`endif
   end

   // The first byte is issued straight from tx_word so tx_wr is high during
   // LOAD; ARM then absorbs the one-cycle lag of uart_busy behind tx_wr.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         shadow   <= '0;
         byte_idx <= '0;
         start_q  <= 1'b0;
         tx_ready <= 1'b1;
         tx_byte  <= '0;
         tx_wr    <= 1'b0;
         tx_done  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
         chk      <= '0;
`endif
      end else begin
         start_q <= tx_start;
         tx_wr   <= 1'b0;
         tx_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx_start && !start_q) begin
                  tx_byte  <= tx_word[WORD_W-1 -: BYTE_W];
                  shadow   <= tx_word << BYTE_W;
                  byte_idx <= IDX_W'(TOTAL - 1);
                  tx_wr    <= 1'b1;
                  tx_ready <= 1'b0;
                  state    <= ST_LOAD;
`ifdef UART_FRAME_CHECKSUM_EN
                  chk      <= tx_word[WORD_W-1 -: BYTE_W];
`endif
               end
            end
            ST_LOAD: state <= ST_ARM;
            ST_ARM:  state <= ST_WAIT;
            ST_WAIT: begin
               if (!uart_busy) begin
                  if (byte_idx != '0) begin
                     tx_byte  <= next_byte;
                     shadow   <= shadow << BYTE_W;
                     byte_idx <= byte_idx - IDX_W'(1);
                     tx_wr    <= 1'b1;
                     state    <= ST_LOAD;
`ifdef UART_FRAME_CHECKSUM_EN
                     chk      <= chk ^ shadow[WORD_W-1 -: BYTE_W];
`endif
                  end else begin
                     tx_done <= 1'b1;
                     state   <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               tx_ready <= 1'b1;
               state    <= ST_IDLE;
            end
            default: begin
               tx_ready <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_frame_link.sv
// +--------------------------------------------------------------------------+
// | uart_frame_link : RX frame assembler with timeout plus TX word sequencer. |
// | Optional XOR checksum byte when UART_FRAME_CHECKSUM_EN is defined.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_frame_link
   import uart_frame_pkg::*;
#(
   parameter int RX_BYTES   = 80,
   parameter int TX_BYTES   = 4,
   parameter int RX_TIMEOUT = 50000000
)(
   input  wire                         clock,
   input  wire                         reset,
   uart_frame_link_if.master           uart,
   output logic [BYTE_W*RX_BYTES-1:0]  header,
   output logic                        header_valid,
   output logic                        rx_error,
   input  wire  [BYTE_W*TX_BYTES-1:0]  tx_word,
   input  wire                         tx_start,
   output logic                        tx_ready,
   output logic                        tx_done
);

`ifdef UART_FRAME_CHECKSUM_EN
   localparam int CHK_BYTES = 1;
`else
   localparam int CHK_BYTES = 0;
`endif
   localparam int RX_TOTAL   = RX_BYTES + CHK_BYTES;
   localparam int CNT_W      = cnt_width(RX_TOTAL);
   localparam int HDR_W      = BYTE_W * RX_BYTES;
   localparam int TO_W       = cnt_width(RX_TIMEOUT);
   localparam bit TIMEOUT_EN = (RX_TIMEOUT != 0);

   logic [CNT_W-1:0] rx_cnt;
   logic [HDR_W-1:0] assembly;
   logic [HDR_W-1:0] assembly_next;
   logic [TO_W-1:0]  to_cnt;
   logic             rdy_clr_q;
   logic             accept;
   logic             last_byte;
   logic             partial;
   logic             expired;
`ifdef UART_FRAME_CHECKSUM_EN
   logic [BYTE_W-1:0] rx_xor;
`endif

   assign uart.rx_rdy_clr = rdy_clr_q;

   // rx_rdy is still high while the clear pulse is out; masking it with the
   // pulse gives exactly one accept per UART byte.
   always_comb begin
      accept        = uart.rx_rdy && !rdy_clr_q;
      last_byte     = (rx_cnt == CNT_W'(RX_TOTAL - 1));
      partial       = (rx_cnt != '0);
      expired       = TIMEOUT_EN && partial && !accept &&
                      (to_cnt == TO_W'(RX_TIMEOUT - 1));
      assembly_next = (assembly << BYTE_W) | HDR_W'(uart.rx_byte);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_cnt       <= '0;
         assembly     <= '0;
         to_cnt       <= '0;
         rdy_clr_q    <= 1'b0;
         header       <= '0;
         header_valid <= 1'b0;
         rx_error     <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
         rx_xor       <= '0;
`endif
      end else begin
         rdy_clr_q    <= accept;
         header_valid <= 1'b0;
         rx_error     <= 1'b0;
         if (accept) begin
            to_cnt <= '0;
            if (last_byte) begin
               rx_cnt <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
               rx_xor <= '0;
               if (uart.rx_byte == rx_xor) begin
                  header       <= assembly;
                  header_valid <= 1'b1;
               end else begin
                  rx_error <= 1'b1;
               end
`else
               header       <= assembly_next;
               header_valid <= 1'b1;
`endif
            end else begin
               rx_cnt   <= rx_cnt + CNT_W'(1);
               assembly <= assembly_next;
`ifdef UART_FRAME_CHECKSUM_EN
               rx_xor   <= rx_xor ^ uart.rx_byte;
`endif
            end
         end else if (expired) begin
            rx_cnt   <= '0;
            to_cnt   <= '0;
            rx_error <= 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            rx_xor   <= '0;
`endif
         end else if (partial && TIMEOUT_EN) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
      end
   end

   uart_frame_tx_seq #(
      .TX_BYTES (TX_BYTES)
   ) u_tx_seq (
      .clock     (clock),
      .reset     (reset),
      .tx_word   (tx_word),
      .tx_start  (tx_start),
      .uart_busy (uart.uart_busy),
      .tx_ready  (tx_ready),
      .tx_byte   (uart.tx_byte),
      .tx_wr     (uart.tx_wr),
      .tx_done   (tx_done)
   );

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_link.sv
// +--------------------------------------------------------------------------+
// | tb_uart_frame_link : directed bench for uart_frame_link (4/4/1000 build). |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_frame_link;

   localparam int BUSY = 100;
`ifdef UART_FRAME_CHECKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif
   localparam int TXN = 4 + CHK;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] header;
   logic        header_valid, rx_error, tx_ready, tx_done;
   logic [31:0] tx_word = '0;
   logic        tx_start = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int nwr = 0, ndone = 0, nhv = 0, nerr = 0, nclr = 0;
   logic [7:0] txb [0:31];

   always #5 clk = ~clk;

   uart_frame_link_if uart ();

   uart_frame_link #(
      .RX_BYTES   (4),
      .TX_BYTES   (4),
      .RX_TIMEOUT (1000)
   ) dut (
      .clock        (clk),
      .reset        (rst_n),
      .uart         (uart.master),
      .header       (header),
      .header_valid (header_valid),
      .rx_error     (rx_error),
      .tx_word      (tx_word),
      .tx_start     (tx_start),
      .tx_ready     (tx_ready),
      .tx_done      (tx_done)
   );

   always @(negedge clk) begin
      if (uart.tx_wr) begin
         if (nwr < 32) txb[nwr] = uart.tx_byte;
         nwr++;
      end
      if (tx_done)         ndone++;
      if (header_valid)    nhv++;
      if (rx_error)        nerr++;
      if (uart.rx_rdy_clr) nclr++;
   end

   // UART transmitter: busy rises one cycle after tx_wr, lasts BUSY cycles.
   initial begin
      uart.uart_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (uart.tx_wr && rst_n) begin
            @(negedge clk);
            uart.uart_busy = 1'b1;
            for (int i = 0; i < BUSY; i++) begin
               @(negedge clk);
               if (!rst_n) break;
            end
            uart.uart_busy = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic hv, output logic err);
      int k;
      @(negedge clk);
      uart.rx_byte = b;
      uart.rx_rdy  = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!uart.rx_rdy_clr && k < 20);
      check("rx_rdy_clr_latency", 64'(k), 64'd1);
      hv  = header_valid;
      err = rx_error;
      @(negedge clk);
      check("rx_rdy_clr_single", {63'd0, uart.rx_rdy_clr}, 64'd0);
      uart.rx_rdy = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] w, input int gap, output logic hv, output logic err);
      logic [7:0] bs [0:4];
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 4; i++) begin
         bs[i] = w[31-8*i -: 8];
         x     = x ^ bs[i];
      end
      bs[4] = x;
      for (int i = 0; i < 4 + CHK; i++) begin
         send_byte(bs[i], hv, err);
         if (i < 3 + CHK) begin
            check("header_valid_early", {63'd0, hv}, 64'd0);
            repeat (gap) @(negedge clk);
         end
      end
   endtask

   task automatic run_tx(input logic [31:0] w, input logic [31:0] w_after);
      int k, bad, n0, d0;
      logic [7:0] exp_b;
      logic [7:0] x;
      n0 = nwr;
      d0 = ndone;
      @(negedge clk);
      tx_word  = w;
      tx_start = 1'b1;
      @(negedge clk);
      tx_word = w_after;
      check("tx_ready_after_start", {63'd0, tx_ready}, 64'd0);
      k = 0;
      bad = 0;
      while (!tx_done && k < 3000) begin
         @(negedge clk);
         k++;
         if (tx_ready) bad++;
      end
      check("tx_done_seen", {63'd0, tx_done}, 64'd1);
      check("tx_ready_low_throughout", 64'(bad), 64'd0);
      @(negedge clk);
      check("tx_ready_idle", {63'd0, tx_ready}, 64'd1);
      tx_start = 1'b0;
      repeat (5) @(negedge clk);
      check("tx_wr_count", 64'(nwr - n0), 64'(TXN));
      check("tx_done_count", 64'(ndone - d0), 64'd1);
      x = 8'h00;
      for (int i = 0; i < 4; i++) begin
         exp_b = w[31-8*i -: 8];
         x     = x ^ exp_b;
         check("tx_byte", {56'd0, txb[n0+i]}, {56'd0, exp_b});
      end
      if (CHK != 0) check("tx_checksum_byte", {56'd0, txb[n0+4]}, {56'd0, x});
   endtask

   initial begin
      logic hv, err;
      int k, n0, d0, h0, e0, c0;

      uart.rx_byte = 8'h00;
      uart.rx_rdy  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_header", {32'd0, header}, 64'd0);
      check("rst_header_valid", {63'd0, header_valid}, 64'd0);
      check("rst_rx_error", {63'd0, rx_error}, 64'd0);
      check("rst_rx_rdy_clr", {63'd0, uart.rx_rdy_clr}, 64'd0);
      check("rst_tx_ready", {63'd0, tx_ready}, 64'd1);
      check("rst_tx_wr", {63'd0, uart.tx_wr}, 64'd0);
      check("rst_tx_byte", {56'd0, uart.tx_byte}, 64'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Frame DEADBEEF with 20-cycle gaps.
      h0 = nhv; e0 = nerr; c0 = nclr;
      send_frame(32'hDEADBEEF, 20, hv, err);
      check("rx1_header_valid_latency", {63'd0, hv}, 64'd1);
      repeat (3) @(negedge clk);
      check("rx1_header", {32'd0, header}, 64'hDEADBEEF);
      check("rx1_hv_pulses", 64'(nhv - h0), 64'd1);
      check("rx1_clr_pulses", 64'(nclr - c0), 64'(4 + CHK));
      check("rx1_no_error", 64'(nerr - e0), 64'd0);

      // TX with tx_word altered after the start edge.
      run_tx(32'h12345678, 32'hFFFFFFFF);

      // Partial frame stalls into the timeout.
      e0 = nerr; h0 = nhv;
      send_byte(8'hAA, hv, err);
      repeat (20) @(negedge clk);
      send_byte(8'hBB, hv, err);
      k = 0;
      while (!rx_error && k < 1500) begin
         @(negedge clk);
         k++;
      end
      check("timeout_window", {63'd0, (k >= 990 && k <= 1010)}, 64'd1);
      repeat (3) @(negedge clk);
      check("timeout_err_pulses", 64'(nerr - e0), 64'd1);
      check("timeout_header_kept", {32'd0, header}, 64'hDEADBEEF);
      check("timeout_no_hv", 64'(nhv - h0), 64'd0);
      send_frame(32'h01020304, 5, hv, err);
      check("rx2_hv", {63'd0, hv}, 64'd1);
      @(negedge clk);
      check("rx2_header", {32'd0, header}, 64'h01020304);

      // tx_start held high with a second rising edge mid-transfer.
      n0 = nwr; d0 = ndone;
      @(negedge clk);
      tx_word  = 32'hA1B2C3D4;
      tx_start = 1'b1;
      repeat (200) @(negedge clk);
      tx_start = 1'b0;
      @(negedge clk);
      tx_start = 1'b1;
      repeat (4800) @(negedge clk);
      tx_start = 1'b0;
      repeat (3) @(negedge clk);
      check("hold_wr_count", 64'(nwr - n0), 64'(TXN));
      check("hold_done_count", 64'(ndone - d0), 64'd1);
      check("hold_byte0", {56'd0, txb[n0]}, 64'hA1);
      check("hold_byte3", {56'd0, txb[n0+3]}, 64'hD4);
      if (CHK != 0) check("hold_checksum", {56'd0, txb[n0+4]}, 64'h04);

      // Asynchronous reset during TX byte 2 and RX byte 3.
      n0 = nwr;
      @(negedge clk);
      tx_word  = 32'h11223344;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      send_byte(8'hC0, hv, err);
      repeat (60) @(negedge clk);
      send_byte(8'hC1, hv, err);
      repeat (60) @(negedge clk);
      check("pre_reset_wr_count", 64'(nwr - n0), 64'd2);
      @(negedge clk);
      uart.rx_byte = 8'hC2;
      uart.rx_rdy  = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_header", {32'd0, header}, 64'd0);
      check("async_tx_ready", {63'd0, tx_ready}, 64'd1);
      check("async_tx_wr", {63'd0, uart.tx_wr}, 64'd0);
      check("async_tx_byte", {56'd0, uart.tx_byte}, 64'd0);
      check("async_rx_rdy_clr", {63'd0, uart.rx_rdy_clr}, 64'd0);
      uart.rx_rdy = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      h0 = nhv; d0 = ndone; e0 = nerr; n0 = nwr;
      repeat (300) @(negedge clk);
      check("post_reset_no_strobes", 64'((nhv - h0) + (ndone - d0) + (nerr - e0) + (nwr - n0)), 64'd0);
      send_frame(32'hCAFEF00D, 10, hv, err);
      check("rx3_hv", {63'd0, hv}, 64'd1);
      @(negedge clk);
      check("rx3_header", {32'd0, header}, 64'hCAFEF00D);

`ifdef UART_FRAME_CHECKSUM_EN
      send_byte(8'hAA, hv, err);
      send_byte(8'h55, hv, err);
      send_byte(8'h00, hv, err);
      send_byte(8'hFF, hv, err);
      send_byte(8'h00, hv, err);
      check("chk_good_hv", {63'd0, hv}, 64'd1);
      @(negedge clk);
      check("chk_good_header", {32'd0, header}, 64'hAA5500FF);
      send_byte(8'hAA, hv, err);
      send_byte(8'h55, hv, err);
      send_byte(8'h00, hv, err);
      send_byte(8'hFF, hv, err);
      send_byte(8'h01, hv, err);
      check("chk_bad_err", {63'd0, err}, 64'd1);
      check("chk_bad_no_hv", {63'd0, hv}, 64'd0);
      @(negedge clk);
      check("chk_bad_header_kept", {32'd0, header}, 64'hAA5500FF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
